// File: rtl/lut_loader_pkg.sv
// Shared types for the runtime-writable lookup table.
package lut_loader_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        LOADED  = 2'd2
    } lut_loader_state_t;

endpackage

// File: rtl/lut_loader_if.sv
// Write stream plus random-access read port of the lookup table.
interface lut_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  load_start;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic                  loaded;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;

    modport master (
        output load_start, data_in, data_in_valid, addr,
        input  data_in_ready, loaded, data, data_valid
    );

    modport slave (
        input  load_start, data_in, data_in_valid, addr,
        output data_in_ready, loaded, data, data_valid
    );
endinterface

// File: rtl/lut_loader.sv
// Lookup table filled sequentially from a valid/ready stream, read by address.
module lut_loader
    import lut_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 13,
    parameter bit OUTPUT_REG = 1'b0
) (
    input logic         clk,
    input logic         rst,
    lut_loader_if.slave bus
);
    localparam int ADDR_WIDTH = (SIZE == 1) ? 1 : $clog2(SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SIZE - 1);

    if (SIZE < 1) begin : g_bad_size
        $error("lut_loader: SIZE must be > 0");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("lut_loader: DATA_WIDTH must be > 0");
    end

    lut_loader_state_t     state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  wr_en;
    logic                  ready;
    logic [DATA_WIDTH-1:0] tab [0:SIZE-1];
    logic [DATA_WIDTH-1:0] look_up;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        ready    = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            LOADING: begin
                // A restart masks ready so the restart cycle never writes.
                ready = !bus.load_start;
                if (bus.load_start) begin
                    wr_ptr_d = '0;
                end else if (bus.data_in_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == LAST) begin
                        state_d  = LOADED;
                        wr_ptr_d = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                if (bus.load_start) begin
                    state_d  = LOADING;
                    wr_ptr_d = '0;
                end
            end
        endcase
    end

    // Table contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) tab[wr_ptr_q] <= bus.data_in;
    end

    assign look_up           = (32'(bus.addr) < SIZE) ? tab[bus.addr] : '0;
    assign bus.data_in_ready = ready;
    assign bus.loaded        = (state_q == LOADED);

    if (OUTPUT_REG) begin : g_reg_out
        logic [DATA_WIDTH-1:0] data_q;
        logic                  valid_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= look_up;
                valid_q <= (state_q == LOADED);
            end
        end
        assign bus.data       = data_q;
        assign bus.data_valid = valid_q;
    end else begin : g_comb_out
        assign bus.data       = look_up;
        assign bus.data_valid = (state_q == LOADED);
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            assert (!$isunknown(bus.data_in))
            else $error("lut_loader: X on data_in during a transfer");
        end
    end
`endif

endmodule

// File: tb/tb_lut_loader.sv
// Drives one stimulus stream into a combinational-read and a registered-read lut_loader.
module tb_lut_loader;
    localparam int DW = 8;
    localparam int SZ = 13;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          data_in_valid;
    logic [DW-1:0] data_in;
    logic [AW-1:0] addr;

    always #5 clk = ~clk;

    lut_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
    lut_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

    assign b0.load_start    = load_start;
    assign b0.data_in       = data_in;
    assign b0.data_in_valid = data_in_valid;
    assign b0.addr          = addr;
    assign b1.load_start    = load_start;
    assign b1.data_in       = data_in;
    assign b1.data_in_valid = data_in_valid;
    assign b1.addr          = addr;

    lut_loader #(.DATA_WIDTH(DW), .SIZE(SZ), .OUTPUT_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave));
    lut_loader #(.DATA_WIDTH(DW), .SIZE(SZ), .OUTPUT_REG(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave));

    int            passed = 0;
    int            total  = 0;
    logic [DW-1:0] model [0:SZ-1];
    int            mptr = 0;
    logic [DW-1:0] exp_q [$];

    function automatic logic [DW-1:0] exp_of(input int a);
        return (a < SZ) ? model[a] : 8'h00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 1'b0; data_in_valid = 1'b0; data_in = '0; addr = '0;
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        #2;
        total++;
        if ({b0.loaded, b1.loaded, b0.data_in_ready, b1.data_in_ready} !== 4'b0000) begin
            $display("FAIL reset_flags loaded=%b%b ready=%b%b expected 0000",
                     b0.loaded, b1.loaded, b0.data_in_ready, b1.data_in_ready);
        end else passed++;
        total++;
        if ({b0.data_valid, b1.data_valid} !== 2'b00) begin
            $display("FAIL reset_valid data_valid=%b%b expected 00", b0.data_valid, b1.data_valid);
        end else passed++;
        total++;
        if (b1.data !== 8'h00) begin
            $display("FAIL reset_regdata data=%h expected 00", b1.data);
        end else passed++;
    endtask

    // One-cycle load_start; ready must be low on that cycle in every state.
    task automatic pulse_load_start(input logic v, input logic [DW-1:0] d);
        load_start = 1'b1; data_in_valid = v; data_in = d;
        #2;
        total++;
        if ({b0.data_in_ready, b1.data_in_ready} !== 2'b00) begin
            $display("FAIL start_ready ready=%b%b expected 00", b0.data_in_ready, b1.data_in_ready);
        end else passed++;
        step();
        load_start = 1'b0; data_in_valid = 1'b0;
        mptr = 0;
    endtask

    task automatic send_beats(input logic [DW-1:0] base, input bit toggle, input int n);
        for (int i = 0; i < n; i++) begin
            data_in = base + DW'(i); data_in_valid = 1'b1;
            #2;
            total++;
            if ({b0.data_in_ready, b1.data_in_ready} !== 2'b11) begin
                $display("FAIL beat_ready beat=%0d ready=%b%b expected 11",
                         i, b0.data_in_ready, b1.data_in_ready);
            end else passed++;
            step();
            model[mptr] = base + DW'(i);
            mptr = (mptr == SZ - 1) ? 0 : mptr + 1;
            if (toggle) begin
                data_in_valid = 1'b0; data_in = 8'hEE;
                step();
            end
        end
        data_in_valid = 1'b0;
        #2;
        if (mptr == 0) begin
            total++;
            if ({b0.loaded, b1.loaded, b0.data_valid, b0.data_in_ready, b1.data_in_ready} !== 5'b11100) begin
                $display("FAIL load_done loaded=%b%b valid0=%b ready=%b%b expected 11100",
                         b0.loaded, b1.loaded, b0.data_valid, b0.data_in_ready, b1.data_in_ready);
            end else passed++;
        end
    endtask

    // Scoreboard sweep: combinational result checked in-cycle, registered one cycle later.
    task automatic test_read_sweep(input int lo, input int hi);
        logic [DW-1:0] e;
        for (int a = lo; a <= hi; a++) begin
            addr = AW'(a);
            exp_q.push_back(exp_of(a));
            #2;
            total++;
            if (b0.data !== exp_of(a) || b0.data_valid !== 1'b1) begin
                $display("FAIL read_comb addr=%0d data=%h valid=%b expected %h/1",
                         a, b0.data, b0.data_valid, exp_of(a));
            end else passed++;
            step();
            #2;
            e = exp_q.pop_front();
            total++;
            if (b1.data !== e || b1.data_valid !== 1'b1) begin
                $display("FAIL read_reg addr=%0d data=%h valid=%b expected %h/1",
                         a, b1.data, b1.data_valid, e);
            end else passed++;
        end
    endtask

    task automatic test_back_to_back();
        pulse_load_start(1'b0, 8'h00);
        send_beats(8'h10, 1'b0, SZ);
        step();
        test_read_sweep(0, 0);
        test_read_sweep(12, 12);
        total++;
        if (model[0] !== 8'h10 || model[12] !== 8'h1C) begin
            $display("FAIL b2b_model entry0=%h entry12=%h expected 10/1c", model[0], model[12]);
        end else passed++;
    endtask

    task automatic test_stall();
        pulse_load_start(1'b0, 8'h00);
        send_beats(8'h20, 1'b1, SZ);
        step();
        test_read_sweep(0, 15);
    endtask

    task automatic test_restart();
        pulse_load_start(1'b0, 8'h00);
        send_beats(8'hA0, 1'b0, 5);
        pulse_load_start(1'b1, 8'hA5);
        send_beats(8'h30, 1'b0, SZ);
        step();
        test_read_sweep(0, 12);
    endtask

    task automatic test_read_during_write();
        logic [DW-1:0] old;
        old  = model[0];
        addr = '0;
        pulse_load_start(1'b0, 8'h00);
        #2;
        total++;
        if ({b0.loaded, b1.loaded, b0.data_valid} !== 3'b000) begin
            $display("FAIL rdw_loaded_drop loaded=%b%b valid0=%b expected 000",
                     b0.loaded, b1.loaded, b0.data_valid);
        end else passed++;
        data_in = 8'h55; data_in_valid = 1'b1;
        #1;
        total++;
        if (b0.data !== old) begin
            $display("FAIL rdw_comb_old data=%h expected %h", b0.data, old);
        end else passed++;
        step();
        model[0] = 8'h55; mptr = 1;
        data_in_valid = 1'b0;
        #2;
        total++;
        if (b0.data !== 8'h55 || b1.data !== old) begin
            $display("FAIL rdw_next data0=%h data1=%h expected 55/%h", b0.data, b1.data, old);
        end else passed++;
        step();
        #2;
        total++;
        if (b1.data !== 8'h55) begin
            $display("FAIL rdw_reg_new data=%h expected 55", b1.data);
        end else passed++;
        send_beats(8'h56, 1'b0, SZ - 1);
        step();
        test_read_sweep(0, 12);
    endtask

    task automatic test_reset_mid_load();
        pulse_load_start(1'b0, 8'h00);
        send_beats(8'h70, 1'b0, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        total++;
        if ({b0.loaded, b1.loaded, b0.data_in_ready, b1.data_in_ready,
             b0.data_valid, b1.data_valid} !== 6'b000000) begin
            $display("FAIL rst_mid_load flags=%b%b%b%b%b%b expected 000000",
                     b0.loaded, b1.loaded, b0.data_in_ready, b1.data_in_ready,
                     b0.data_valid, b1.data_valid);
        end else passed++;
        pulse_load_start(1'b0, 8'h00);
        send_beats(8'h80, 1'b0, SZ);
        step();
        test_read_sweep(0, 15);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_restart();
        test_read_during_write();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lut_loader.md
Name: lut_loader

Overview:
- Runtime-writable counterpart of the static lookup table: the write side of the same table interface.
- Accepts a stream of DATA_WIDTH entries over a valid/ready handshake and writes them sequentially into table[0..SIZE-1].
- Serves random-access lookups on a read port with an optional output register.
- Sits in front of activation/approximation units whose tables are programmed by the host or an upstream stream, not by a memfile.

Parameters:
DATA_WIDTH, 8, bit width of each table entry
SIZE, 13, number of entries
OUTPUT_REG, 0, 1 = registered read data (1-cycle latency); 0 = combinational read
ADDR_WIDTH (localparam), SIZE==1 ? 1 : $clog2(SIZE), read address / write pointer width

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
load_start  input  1  single-cycle request to (re)load the full table from entry 0
data_in  input  DATA_WIDTH  entry to write
data_in_valid  input  1  data_in holds a valid entry
data_in_ready  output  1  loader accepts data_in this cycle
loaded  output  1  table fully written since the last load_start
addr  input  ADDR_WIDTH  lookup address
data  output  DATA_WIDTH  lookup result
data_valid  output  1  data comes from a fully loaded table

Behaviour:
- States (enum in package): EMPTY, LOADING, LOADED.
- Reset:
  - state=EMPTY, wr_ptr=0, loaded=0, data_in_ready=0, data_valid=0.
  - If OUTPUT_REG=1, data=0.
  - Table contents are not reset.
- EMPTY or LOADED with load_start=1: next state LOADING, wr_ptr=0, loaded=0.
- LOADING:
  - data_in_ready = !load_start.
  - A beat transfers when data_in_valid && data_in_ready; tab[wr_ptr] <= data_in.
  - If wr_ptr==SIZE-1, next state is LOADED and wr_ptr=0; otherwise wr_ptr+1.
  - load_start during LOADING restarts: wr_ptr=0, stay in LOADING, no write that cycle (ready is low).
- LOADED: data_in_ready=0 and loaded=1; holds until load_start or rst.
- data_in_ready is 0 in EMPTY and LOADED; stalls on data_in_valid=0 keep wr_ptr unchanged.
- Read path:
  - look_up = (addr < SIZE) ? tab[addr] : 0.
  - OUTPUT_REG=0: data=look_up and data_valid=loaded, combinational.
  - OUTPUT_REG=1: data and data_valid are registered copies of look_up and loaded, 1-cycle latency.
- Reads are permitted in every state; data_valid qualifies them.
- Read-during-write to the same address returns the old entry in that cycle. The new entry is visible on the next cycle (OUTPUT_REG=0) or one cycle later (OUTPUT_REG=1).
- SIZE==1: wr_ptr stays 0; the first accepted beat completes the load.
- rst during LOADING: return to EMPTY. Partially written entries remain in the table but loaded=0.
- Assertions (sim only): SIZE>0, DATA_WIDTH>0, no X on data_in when a beat transfers.

Decomposition:
- Package lut_loader_pkg: state enum type lut_loader_state_t (EMPTY, LOADING, LOADED).
- Single module, no sub-module. The write pointer, FSM and read mux are inline; a separate counter is unnecessary at this size.

Test Plan:
- Reset, then idle for 5 cycles -> loaded=0, data_valid=0, data_in_ready=0; data=0 when OUTPUT_REG=1.
- load_start, then 13 back-to-back beats 0x10..0x1C -> ready high for exactly 13 beats, loaded=1 the cycle after the last beat; addr=0 reads 0x10, addr=12 reads 0x1C; with OUTPUT_REG=1 each read appears 1 cycle after addr.
- Load with data_in_valid toggling 1,0,1,0 -> exactly 13 entries written, in order, no skips or duplicates; addr=13..15 reads 0x00.
- load_start after beat 5 of a 0xA0.. load, followed by 13 beats of 0x30.. -> ready low on the restart cycle; all 13 entries read 0x30..0x3C.
- Reload a LOADED table while reading addr=0 during the beat that writes 0x55 to entry 0 -> the old value is returned that cycle and 0x55 afterwards; loaded drops the cycle after load_start.
- rst asserted after beat 7 of a load -> state EMPTY, loaded=0; a new load_start plus 13 beats completes normally.
